// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with wait states, sub-word lanes and access checks
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic accept, go_resp;

    logic        lat_write, lat_unsigned;
    logic [1:0]  lat_size;
    logic [31:0] lat_addr, lat_wdata;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        eff_write, eff_unsigned;
    logic [1:0]  eff_size;
    logic [31:0] eff_addr, eff_wdata;
    logic        access_err;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]  lane_sel;
    logic [3:0]  byte_en;
    logic [31:0] wr_word, rd_word, load_val, resp_data;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    logic [31:0] mem [0:DEPTH-1];

    // State register and wait-state counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and handshake outputs; all outputs forced low while in reset
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        go_resp   = 1'b0;
        req_ready = reset && (state_q == IDLE);
        rsp_valid = reset && (state_q == RESP);
        rsp_rdata = reset ? rdata_q : 32'd0;
        rsp_err   = reset && err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (WS == 4'd0) begin
                        state_d = RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WS;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    go_resp = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The access resolves either from the live request (zero wait states) or the latched copy
    always_comb begin
        eff_write    = (state_q == IDLE) ? req_write    : lat_write;
        eff_size     = (state_q == IDLE) ? req_size     : lat_size;
        eff_unsigned = (state_q == IDLE) ? req_unsigned : lat_unsigned;
        eff_addr     = (state_q == IDLE) ? req_addr     : lat_addr;
        eff_wdata    = (state_q == IDLE) ? req_wdata    : lat_wdata;

        access_err = (eff_size == 2'b11)
                  || ((eff_size == 2'b01) && eff_addr[0])
                  || ((eff_size == 2'b10) && (eff_addr[1:0] != 2'b00))
                  || ((eff_addr >> (ADDR_WIDTH + 2)) != 32'd0);

        word_idx = eff_addr[ADDR_WIDTH+1:2];
        lane_sel = eff_addr[1:0];

        case (eff_size)
            2'b00: begin
                byte_en = 4'b0001 << lane_sel;
                wr_word = {4{eff_wdata[7:0]}};
            end
            2'b01: begin
                byte_en = eff_addr[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{eff_wdata[15:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                wr_word = eff_wdata;
            end
        endcase

        rd_word = mem[word_idx];
        rd_byte = rd_word[{lane_sel, 3'b000} +: 8];
        rd_half = eff_addr[1] ? rd_word[31:16] : rd_word[15:0];

        case (eff_size)
            2'b00:   load_val = eff_unsigned ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   load_val = eff_unsigned ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: load_val = rd_word;
        endcase

        resp_data = (access_err || eff_write) ? 32'd0 : load_val;
    end

    // Request latch and registered response, captured on the edge entering RESP
    always_ff @(posedge clk) begin
        if (!reset) begin
            lat_write    <= 1'b0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_addr     <= 32'd0;
            lat_wdata    <= 32'd0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
        end else begin
            if (accept) begin
                lat_write    <= req_write;
                lat_size     <= req_size;
                lat_unsigned <= req_unsigned;
                lat_addr     <= req_addr;
                lat_wdata    <= req_wdata;
            end
            if (go_resp) begin
                rdata_q <= resp_data;
                err_q   <= access_err;
            end
        end
    end

    // RAM byte-lane write; contents survive reset, and a store still in WAIT is dropped by reset
    always_ff @(posedge clk) begin
        if (reset && go_resp && eff_write && !access_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;

    localparam int AW    = 10;
    localparam int WS    = 1;
    localparam int BYTES = 4 * (2 ** AW);

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit started = 0;

    // transaction-level reference: byte-addressed memory plus one outstanding request
    bit          pend = 0;
    bit          due = 0;
    int          acc_cyc = 0;
    bit          m_write, m_unsigned;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] e_rdata = 32'd0;
    logic        e_err = 1'b0;
    logic [7:0]  ref_mem [0:BYTES-1];

    dmem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // resolve the outstanding access against the byte memory
    task automatic model_resolve();
        int nbytes;
        logic [31:0] v;
        nbytes = (m_size == 2'd0) ? 1 : (m_size == 2'd1) ? 2 : 4;
        e_err = (m_size == 2'd3) || ((m_addr % nbytes) != 0) || (m_addr >= BYTES);
        e_rdata = 32'd0;
        if (!e_err) begin
            if (m_write) begin
                for (int i = 0; i < nbytes; i++) ref_mem[int'(m_addr) + i] = m_wdata[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < nbytes; i++) v = v | (32'(ref_mem[int'(m_addr) + i]) << (8 * i));
                if (!m_unsigned && nbytes < 4 && v[8*nbytes-1]) v = v | (32'hFFFFFFFF << (8 * nbytes));
                e_rdata = v;
            end
        end
    endtask

    task automatic model_step();
        if (!reset) begin
            pend = 0;
            due  = 0;
        end else begin
            if (due && rsp_ready) begin
                pend = 0;
                due  = 0;
            end else if (!pend && req_valid) begin
                pend = 1;
                acc_cyc = cyc;
                m_write = req_write;
                m_size = req_size;
                m_unsigned = req_unsigned;
                m_addr = req_addr;
                m_wdata = req_wdata;
            end
            if (pend && !due && cyc == acc_cyc + WS) begin
                model_resolve();
                due = 1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        cyc++;
        started = 1;
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            chk1("req_ready", req_ready, reset && !pend);
            chk1("rsp_valid", rsp_valid, reset && due);
            if (!reset) begin
                chk32("rsp_rdata_in_reset", rsp_rdata, 32'd0);
                chk1("rsp_err_in_reset", rsp_err, 1'b0);
            end else if (due) begin
                chk32("rsp_rdata", rsp_rdata, e_rdata);
                chk1("rsp_err", rsp_err, e_err);
            end
        end
    end

    // which=0 waits for req_ready, which=1 for rsp_valid; sampled at negedge
    task automatic wait_sig(input string nm, input bit which, output bit ok);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((which == 0) ? !req_ready : !rsp_valid) && n < 50);
        ok = (which == 0) ? req_ready : rsp_valid;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout after %0d cycles", nm, n);
        end
    endtask

    task automatic txn(input string nm, input bit w, input logic [1:0] sz, input bit u,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_e);
        int acc;
        bit ok;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd; rsp_ready = 1'b0;
        wait_sig({nm, "_accept"}, 1'b0, ok);
        acc = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!ok) return;
        wait_sig({nm, "_resp"}, 1'b1, ok);
        if (!ok) return;
        chk32({nm, "_latency"}, 32'(cyc - acc), 32'(1 + WS));
        chk32({nm, "_rdata"}, rsp_rdata, exp_d);
        chk1({nm, "_err"}, rsp_err, exp_e);
        @(posedge clk); #1; rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc;
        bit ok;

        // reset with a request pending: nothing may be accepted or answered
        req_valid = 1'b1; req_size = 2'd2; req_addr = 32'h10;
        repeat (3) begin
            @(negedge clk);
            chk1("rst_req_ready", req_ready, 1'b0);
            chk1("rst_rsp_valid", rsp_valid, 1'b0);
        end
        @(posedge clk); #1;
        reset = 1'b1; req_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk1("post_rst_req_ready", req_ready, 1'b1);
            chk1("post_rst_rsp_valid", rsp_valid, 1'b0);
        end

        // word and sub-word access
        txn("st_w10",   1, 2'd2, 0, 32'h10,   32'hDEADBEEF, 32'h0,        0);
        txn("ld_w10",   0, 2'd2, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0);
        txn("st_b13",   1, 2'd0, 0, 32'h13,   32'hAAAAAA80, 32'h0,        0);
        txn("ld_w10b",  0, 2'd2, 0, 32'h10,   32'h0,        32'h80ADBEEF, 0);
        txn("ld_b13s",  0, 2'd0, 0, 32'h13,   32'h0,        32'hFFFFFF80, 0);
        txn("ld_b13u",  0, 2'd0, 1, 32'h13,   32'h0,        32'h00000080, 0);
        txn("ld_h12s",  0, 2'd1, 0, 32'h12,   32'h0,        32'hFFFF80AD, 0);
        txn("ld_h10u",  0, 2'd1, 1, 32'h10,   32'h0,        32'h0000BEEF, 0);
        txn("ld_w10u",  0, 2'd2, 1, 32'h10,   32'h0,        32'h80ADBEEF, 0);

        // error cases
        txn("st_w20",   1, 2'd2, 0, 32'h20,   32'h01020304, 32'h0,        0);
        txn("st_w22",   1, 2'd2, 0, 32'h22,   32'h11111111, 32'h0,        1);
        txn("ld_w20",   0, 2'd2, 0, 32'h20,   32'h0,        32'h01020304, 0);
        txn("ld_h13",   0, 2'd1, 0, 32'h13,   32'h0,        32'h0,        1);
        txn("ld_sz3",   0, 2'd3, 0, 32'h10,   32'h0,        32'h0,        1);
        txn("ld_1000",  0, 2'd2, 0, 32'h1000, 32'h0,        32'h0,        1);
        txn("st_b1000", 1, 2'd0, 0, 32'h1000, 32'h000000FF, 32'h0,        1);
        txn("st_h11",   1, 2'd1, 0, 32'h11,   32'h0000FFFF, 32'h0,        1);
        txn("ld_w10c",  0, 2'd2, 0, 32'h10,   32'h0,        32'h80ADBEEF, 0);

        // top of the address range and half store
        txn("st_bfff",  1, 2'd0, 0, 32'hFFF,  32'h1234565A, 32'h0,        0);
        txn("ld_bfff",  0, 2'd0, 0, 32'hFFF,  32'h0,        32'h0000005A, 0);
        txn("st_h12",   1, 2'd1, 0, 32'h12,   32'hFFFF5678, 32'h0,        0);
        txn("ld_w10d",  0, 2'd2, 0, 32'h10,   32'h0,        32'h5678BEEF, 0);

        // backpressure with a second request held
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h10; rsp_ready = 1'b0;
        wait_sig("bp_accept1", 1'b0, ok);
        acc = cyc;
        @(posedge clk); #1;
        req_size = 2'd0; req_unsigned = 1'b1;
        wait_sig("bp_resp1", 1'b1, ok);
        chk32("bp_latency1", 32'(cyc - acc), 32'(1 + WS));
        for (int i = 0; i < 4; i++) begin
            chk32("bp_rdata_hold", rsp_rdata, 32'h5678BEEF);
            chk1("bp_valid_hold", rsp_valid, 1'b1);
            chk1("bp_err_hold", rsp_err, 1'b0);
            chk1("bp_ready_low", req_ready, 1'b0);
            if (i < 3) @(negedge clk);
        end
        @(posedge clk); #1; rsp_ready = 1'b1;
        @(negedge clk);
        chk1("bp_ready_hs_cycle", req_ready, 1'b0);
        @(posedge clk); #1; rsp_ready = 1'b0;
        @(negedge clk);
        chk1("bp_ready_after_hs", req_ready, 1'b1);
        acc = cyc;
        @(posedge clk); #1; req_valid = 1'b0;
        wait_sig("bp_resp2", 1'b1, ok);
        chk32("bp_latency2", 32'(cyc - acc), 32'(1 + WS));
        chk32("bp_rdata2", rsp_rdata, 32'h000000EF);
        @(posedge clk); #1; rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;

        // reset during WAIT discards the store
        txn("st_w40",   1, 2'd2, 0, 32'h40,   32'hCAFEF00D, 32'h0,        0);
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h40; req_wdata = 32'h12345678;
        wait_sig("mid_accept", 1'b0, ok);
        @(posedge clk); #1;
        req_valid = 1'b0; reset = 1'b0;
        @(negedge clk);
        chk1("mid_rst_valid", rsp_valid, 1'b0);
        @(posedge clk); #1; reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk1("mid_no_resp", rsp_valid, 1'b0);
            chk1("mid_ready", req_ready, 1'b1);
        end
        txn("ld_w40",   0, 2'd2, 0, 32'h40,   32'h0,        32'hCAFEF00D, 0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
